// File: rtl/pacman_pkg.sv
// Shared types and helpers for the maze-game sprite movement logic.
package pacman_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_RD,
    ST_REQ_WAIT,
    ST_HEAD_RD,
    ST_HEAD_WAIT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  // Request bits are {up,down,left,right}; up wins, then down, left, right.
  function automatic dir_t decode_dir(input logic [3:0] req);
    dir_t d;
    if (req[3]) d = DIR_UP;
    else if (req[2]) d = DIR_DOWN;
    else if (req[1]) d = DIR_LEFT;
    else if (req[0]) d = DIR_RIGHT;
    else d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/sprite_move_engine_grid_step.sv
// Combinational one-tile step on the maze grid, with optional horizontal
// tunnel wrap-around. DIR_NONE returns the input tile unchanged.
module grid_step
  import pacman_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int IDX_W  = 10,
  parameter int WRAP_X = 1
) (
  input  logic [IDX_W-1:0] idx,
  input  dir_t             dir,
  output logic [IDX_W-1:0] cand,
  output logic             off_grid
);

  localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(GRID_W);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(GRID_W - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(GRID_H - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;

  assign row = idx / ROW_STEP;
  assign col = idx % ROW_STEP;

  // Candidate tile and edge detection for the requested direction.
  always_comb begin
    cand     = idx;
    off_grid = 1'b0;
    case (dir)
      DIR_UP: begin
        if (row == '0) off_grid = 1'b1;
        else cand = idx - ROW_STEP;
      end
      DIR_DOWN: begin
        if (row == LAST_ROW) off_grid = 1'b1;
        else cand = idx + ROW_STEP;
      end
      DIR_LEFT: begin
        if (col == '0) begin
          if (WRAP_X != 0) cand = idx + LAST_COL;
          else off_grid = 1'b1;
        end else begin
          cand = idx - ONE;
        end
      end
      DIR_RIGHT: begin
        if (col == LAST_COL) begin
          if (WRAP_X != 0) cand = idx - LAST_COL;
          else off_grid = 1'b1;
        end else begin
          cand = idx + ONE;
        end
      end
      default: begin
        cand     = idx;
        off_grid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sprite_move_engine.sv
// Multi-sprite tile movement engine. On each tick it walks the sprites one
// at a time, tries the fresh request first, falls back to the buffered
// heading, and checks walls through a single shared maze-ROM read port.
module sprite_move_engine
  import pacman_pkg::*;
#(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int IDX_W     = 10,
  parameter int N_SPRITES = 4,
  parameter int WALL_LAT  = 1,
  parameter int WRAP_X    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         ready,
  input  logic [4*N_SPRITES-1:0]       dir_req,
  input  logic [IDX_W*N_SPRITES-1:0]   curr_block,
  output logic                         wall_rd,
  output logic [IDX_W-1:0]             wall_addr,
  input  logic                         wall_q,
  output logic [IDX_W*N_SPRITES-1:0]   next_block,
  output logic [N_SPRITES-1:0]         moved,
  output logic                         done
);

  localparam int CNT_W = $clog2(WALL_LAT + 1);
  localparam int SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [IDX_W:0]   N_TILES  = (IDX_W + 1)'(GRID_W * GRID_H);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(WALL_LAT);

  state_t state, state_nx;

  logic [SEL_W-1:0] sprite;
  logic [IDX_W-1:0] curr_lat [N_SPRITES];
  dir_t             req_lat  [N_SPRITES];
  dir_t             heading  [N_SPRITES];
  logic [IDX_W-1:0] result;
  logic [CNT_W-1:0] wait_cnt;

  logic [IDX_W-1:0] curr_sel;
  dir_t             req_sel;
  dir_t             head_sel;
  dir_t             step_dir;
  logic [IDX_W-1:0] cand;
  logic             off_grid;
  logic             curr_valid;
  logic             last_sprite;

  logic             issue_rd;
  logic             res_we;
  logic [IDX_W-1:0] res_val;
  logic             head_we;
  dir_t             head_val;
  logic             commit;

  // Pick the latched tile, request and heading of the sprite being processed.
  always_comb begin
    curr_sel = '0;
    req_sel  = DIR_NONE;
    head_sel = DIR_NONE;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (sprite == SEL_W'(i)) begin
        curr_sel = curr_lat[i];
        req_sel  = req_lat[i];
        head_sel = heading[i];
      end
    end
  end

  assign curr_valid  = ({1'b0, curr_sel} < N_TILES);
  assign last_sprite = (sprite == SEL_W'(N_SPRITES - 1));
  assign step_dir    = (state == ST_HEAD_RD || state == ST_HEAD_WAIT) ? head_sel : req_sel;
  assign ready       = (state == ST_IDLE);
  assign done        = (state == ST_DONE);

  grid_step #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .IDX_W (IDX_W),
    .WRAP_X(WRAP_X)
  ) u_step (
    .idx     (curr_sel),
    .dir     (step_dir),
    .cand    (cand),
    .off_grid(off_grid)
  );

  // State register; reset aborts any tick in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    state_nx = state;
    issue_rd = 1'b0;
    res_we   = 1'b0;
    res_val  = curr_sel;
    head_we  = 1'b0;
    head_val = DIR_NONE;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_REQ_RD;
      end
      ST_REQ_RD: begin
        if (!curr_valid) begin
          res_we   = 1'b1;
          res_val  = curr_sel;
          state_nx = ST_COMMIT;
        end else if (req_sel == DIR_NONE || off_grid) begin
          state_nx = ST_HEAD_RD;
        end else begin
          issue_rd = 1'b1;
          state_nx = ST_REQ_WAIT;
        end
      end
      ST_REQ_WAIT: begin
        if (wait_cnt == '0) begin
          if (!wall_q) begin
            res_we   = 1'b1;
            res_val  = cand;
            head_we  = 1'b1;
            head_val = req_sel;
            state_nx = ST_COMMIT;
          end else begin
            state_nx = ST_HEAD_RD;
          end
        end
      end
      ST_HEAD_RD: begin
        if (head_sel == DIR_NONE || off_grid) begin
          res_we   = 1'b1;
          res_val  = curr_sel;
          head_we  = 1'b1;
          head_val = DIR_NONE;
          state_nx = ST_COMMIT;
        end else begin
          issue_rd = 1'b1;
          state_nx = ST_HEAD_WAIT;
        end
      end
      ST_HEAD_WAIT: begin
        if (wait_cnt == '0) begin
          res_we   = 1'b1;
          state_nx = ST_COMMIT;
          if (!wall_q) begin
            res_val = cand;
          end else begin
            head_we  = 1'b1;
            head_val = DIR_NONE;
          end
        end
      end
      ST_COMMIT: begin
        commit   = 1'b1;
        state_nx = last_sprite ? ST_DONE : ST_REQ_RD;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // ROM strobe, latency counter, input latch, headings and committed results.
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite     <= '0;
      result     <= '0;
      wait_cnt   <= '0;
      wall_rd    <= 1'b0;
      wall_addr  <= '0;
      next_block <= '0;
      moved      <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        curr_lat[i] <= '0;
        req_lat[i]  <= DIR_NONE;
        heading[i]  <= DIR_NONE;
      end
    end else begin
      wall_rd <= issue_rd;
      if (issue_rd) begin
        wall_addr <= cand;
        wait_cnt  <= LAT_LOAD;
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      if (state == ST_IDLE && start) begin
        sprite <= '0;
        for (int i = 0; i < N_SPRITES; i++) begin
          curr_lat[i] <= curr_block[i*IDX_W +: IDX_W];
          req_lat[i]  <= decode_dir(dir_req[4*i +: 4]);
        end
      end
      if (res_we) result <= res_val;
      for (int i = 0; i < N_SPRITES; i++) begin
        if (sprite == SEL_W'(i)) begin
          if (head_we) heading[i] <= head_val;
          if (commit) begin
            next_block[i*IDX_W +: IDX_W] <= result;
            moved[i]                     <= (result != curr_lat[i]);
          end
        end
      end
      if (commit && !last_sprite) sprite <= sprite + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_sprite_move_engine.sv
// Scoreboard bench for sprite_move_engine: three instances (single sprite
// with tunnel wrap, single sprite without wrap, four sprites with slow ROM),
// each fed by its own maze-ROM model with the configured read latency.
module tb_sprite_move_engine;

  typedef struct {
    int          dut;
    logic [39:0] nb;
    logic [3:0]  mv;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  start_v;
  logic [15:0] dir_v;
  logic [39:0] curr_v;

  logic        ready_w [3];
  logic        done_w  [3];
  logic        rd_w    [3];
  logic        q_w     [3];
  logic [9:0]  addr_w  [3];
  logic [39:0] nb_w    [3];
  logic [3:0]  mv_w    [3];

  logic [9:0]  nb_a, nb_b;
  logic [39:0] nb_c;
  logic        mv_a, mv_b;
  logic [3:0]  mv_c;

  logic        walls [3][1024];
  logic [3:0]  pv [3];
  logic [3:0]  pd [3];

  exp_t sb[$];
  int   checks;
  int   errors;
  int   done_cnt [3];
  int   rd_cnt   [3];

  sprite_move_engine #(.GRID_W(32), .GRID_H(24), .IDX_W(10), .N_SPRITES(1), .WALL_LAT(1), .WRAP_X(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .ready(ready_w[0]),
    .dir_req(dir_v[3:0]), .curr_block(curr_v[9:0]),
    .wall_rd(rd_w[0]), .wall_addr(addr_w[0]), .wall_q(q_w[0]),
    .next_block(nb_a), .moved(mv_a), .done(done_w[0]));

  sprite_move_engine #(.GRID_W(32), .GRID_H(24), .IDX_W(10), .N_SPRITES(1), .WALL_LAT(1), .WRAP_X(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .ready(ready_w[1]),
    .dir_req(dir_v[3:0]), .curr_block(curr_v[9:0]),
    .wall_rd(rd_w[1]), .wall_addr(addr_w[1]), .wall_q(q_w[1]),
    .next_block(nb_b), .moved(mv_b), .done(done_w[1]));

  sprite_move_engine #(.GRID_W(32), .GRID_H(24), .IDX_W(10), .N_SPRITES(4), .WALL_LAT(3), .WRAP_X(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .ready(ready_w[2]),
    .dir_req(dir_v), .curr_block(curr_v),
    .wall_rd(rd_w[2]), .wall_addr(addr_w[2]), .wall_q(q_w[2]),
    .next_block(nb_c), .moved(mv_c), .done(done_w[2]));

  assign nb_w[0] = {30'd0, nb_a};
  assign nb_w[1] = {30'd0, nb_b};
  assign nb_w[2] = nb_c;
  assign mv_w[0] = {3'd0, mv_a};
  assign mv_w[1] = {3'd0, mv_b};
  assign mv_w[2] = mv_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maze ROM models: answer arrives exactly WALL_LAT cycles after the strobe,
  // and reads as a wall in every other cycle so mistimed sampling shows up.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pv[k] <= {pv[k][2:0], rd_w[k]};
      pd[k] <= {pd[k][2:0], walls[k][addr_w[k]]};
    end
  end

  assign q_w[0] = pv[0][0] ? pd[0][0] : 1'b1;
  assign q_w[1] = pv[1][0] ? pd[1][0] : 1'b1;
  assign q_w[2] = pv[2][2] ? pd[2][2] : 1'b1;

  // Monitor: counts strobes and done pulses, pops the scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rd_w[k] === 1'b1) rd_cnt[k] = rd_cnt[k] + 1;
      if (done_w[k] === 1'b1) begin
        done_cnt[k] = done_cnt[k] + 1;
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("[TB] FAIL unexpected_done dut%0d: got done=1, expected no pending tick", k);
        end else begin
          e = sb.pop_front();
          checks = checks + 1;
          if (e.dut != k || nb_w[k] !== e.nb) begin
            errors = errors + 1;
            $display("[TB] FAIL next_block dut%0d: got %h, expected %h (queued for dut%0d)", k, nb_w[k], e.nb, e.dut);
          end
          checks = checks + 1;
          if (mv_w[k] !== e.mv) begin
            errors = errors + 1;
            $display("[TB] FAIL moved dut%0d: got %b, expected %b", k, mv_w[k], e.mv);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one tick on instance sel, queue its expected result and wait for done.
  task automatic applyStimulus(input int sel, input logic [39:0] curr, input logic [15:0] dir,
                               input logic [39:0] exp_nb, input logic [3:0] exp_mv,
                               input bit poke, output int lat);
    exp_t e;
    int   waited;
    int   dc0;
    waited = 0;
    while (ready_w[sel] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_start", 40'(ready_w[sel]), 40'd1);
    e.dut = sel;
    e.nb  = exp_nb;
    e.mv  = exp_mv;
    sb.push_back(e);
    dc0 = done_cnt[sel];
    curr_v = curr;
    dir_v  = dir;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    curr_v = '0;
    dir_v  = 16'hFFFF;
    lat = 0;
    while (done_w[sel] !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      start_v[sel] = poke && (lat == 2 || lat == 5);
    end
    start_v[sel] = 1'b0;
    checkOutput("done_seen", 40'(done_w[sel]), 40'd1);
    repeat (2) @(negedge clk);
    checkOutput("done_pulses", 40'(done_cnt[sel] - dc0), 40'd1);
  endtask

  // Watchdog so the run always ends even if the design stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int lat;
    int rc0;
    int dc0;
    int waited;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0;
      rd_cnt[k]   = 0;
      pv[k] = '0;
      pd[k] = '0;
      for (int t = 0; t < 1024; t++) walls[k][t] = 1'b0;
    end
    walls[0][463] = 1'b1;
    walls[2][168] = 1'b1;
    walls[2][735] = 1'b1;
    reset   = 1'b1;
    start_v = '0;
    dir_v   = '0;
    curr_v  = '0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_ready", 40'(ready_w[k]), 40'd1);
      checkOutput("reset_done", 40'(done_w[k]), 40'd0);
      checkOutput("reset_wall_rd", 40'(rd_w[k]), 40'd0);
      checkOutput("reset_wall_addr", 40'(addr_w[k]), 40'd0);
      checkOutput("reset_next_block", nb_w[k], 40'd0);
      checkOutput("reset_moved", 40'(mv_w[k]), 40'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] open corridor, moving right");
    for (int c = 495; c <= 501; c++) begin
      applyStimulus(0, 40'(c), 16'h0001, 40'(c + 1), 4'b0001, 1'b0, lat);
      if (c == 495) checkOutput("tick_latency", 40'(lat), 40'd4);
    end

    $display("[TB] blocked request falls back to heading");
    applyStimulus(0, 40'd495, 16'h0008, 40'd496, 4'b0001, 1'b0, lat);
    applyStimulus(0, 40'd496, 16'h0000, 40'd497, 4'b0001, 1'b0, lat);

    $display("[TB] tunnel wrap and grid edges");
    applyStimulus(0, 40'd480, 16'h0002, 40'd511, 4'b0001, 1'b0, lat);
    applyStimulus(1, 40'd480, 16'h0002, 40'd480, 4'b0000, 1'b0, lat);
    applyStimulus(1, 40'd5,   16'h0008, 40'd5,   4'b0000, 1'b0, lat);

    $display("[TB] tile outside the maze");
    rc0 = rd_cnt[0];
    applyStimulus(0, 40'd1000, 16'h0001, 40'd1000, 4'b0000, 1'b0, lat);
    checkOutput("no_rom_read_off_map", 40'(rd_cnt[0] - rc0), 40'd0);

    $display("[TB] four sprites, slow ROM, start pulsed while busy");
    applyStimulus(2, {10'd767, 10'd0, 10'd200, 10'd100},
                  {4'b0100, 4'b0010, 4'b1000, 4'b0001},
                  {10'd767, 10'd31, 10'd200, 10'd101}, 4'b0101, 1'b1, lat);
    applyStimulus(2, {10'd767, 10'd31, 10'd200, 10'd101},
                  {4'b1000, 4'b0000, 4'b0100, 4'b0000},
                  {10'd767, 10'd30, 10'd232, 10'd102}, 4'b0111, 1'b0, lat);

    $display("[TB] reset in the middle of a tick");
    dc0 = done_cnt[0];
    curr_v = 40'd300;
    dir_v  = 16'h0001;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    waited = 0;
    while (rd_w[0] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reached_req_wait", 40'(rd_w[0]), 40'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 40'(ready_w[0]), 40'd1);
    checkOutput("abort_next_block", nb_w[0], 40'd0);
    checkOutput("abort_moved", 40'(mv_w[0]), 40'd0);
    checkOutput("abort_done", 40'(done_w[0]), 40'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", 40'(done_cnt[0] - dc0), 40'd0);
    applyStimulus(0, 40'd300, 16'h0000, 40'd300, 4'b0000, 1'b0, lat);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 40'(sb.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
